// File: rtl/usb_serial_in_ep.sv
// Serial-to-USB IN endpoint. It buffers upstream bytes in a small FIFO and moves them to the protocol engine as packets.
// Short packets and zero-length packets are committed after an idle timeout.
module usb_serial_in_ep #(
    parameter int MAX_PKT       = 64,
    parameter int FIFO_DEPTH    = 16,
    parameter int FLUSH_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        ep_stall,
    output logic        in_ep_req,
    input  logic        in_ep_grant,
    input  logic        in_ep_data_free,
    output logic        in_ep_data_put,
    output logic [7:0]  in_ep_data,
    output logic        in_ep_data_done,
    output logic        in_ep_stall,
    input  logic        in_ep_acked,
    output logic [15:0] pkt_sent_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] fifo_count_reg;
    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [6:0]    pkt_count_reg;
    logic [TW-1:0] timer_reg;
    logic          zlp_pend_reg;
    logic [15:0]   pkt_sent_cnt_reg;

    logic fifo_empty;
    logic push;
    logic pkt_full;
    logic timer_expired;

    assign fifo_empty    = (fifo_count_reg == '0);
    assign s_ready       = (fifo_count_reg < CW'(FIFO_DEPTH));
    assign push          = s_valid && s_ready;
    assign pkt_full      = (pkt_count_reg == 7'(MAX_PKT));
    assign timer_expired = (timer_reg == TW'(FLUSH_TIMEOUT));

    assign in_ep_data_put  = (state_reg == ST_FILL) && in_ep_grant && in_ep_data_free
                             && !fifo_empty && (pkt_count_reg < 7'(MAX_PKT));
    // Head of FIFO is presented combinationally so a put consumes it in the same cycle.
    assign in_ep_data      = mem[rd_ptr_reg];
    assign in_ep_req       = (state_reg != ST_IDLE);
    assign in_ep_data_done = (state_reg == ST_COMMIT);
    assign in_ep_stall     = ep_stall;
    assign pkt_sent_cnt    = pkt_sent_cnt_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (!fifo_empty || (zlp_pend_reg && timer_expired)) state_next = ST_REQ;
            ST_REQ:    if (in_ep_grant) state_next = ST_FILL;
            ST_FILL:   if (pkt_full || (fifo_empty && timer_expired)) state_next = ST_COMMIT;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            fifo_count_reg   <= '0;
            pkt_count_reg    <= '0;
            timer_reg        <= '0;
            zlp_pend_reg     <= 1'b0;
            pkt_sent_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (in_ep_data_put) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, in_ep_data_put})
                2'b10:   fifo_count_reg <= fifo_count_reg + CW'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - CW'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
            if (state_reg == ST_COMMIT) begin
                pkt_count_reg <= '0;
            end else if (in_ep_data_put) begin
                pkt_count_reg <= pkt_count_reg + 7'd1;
            end
            // Any byte movement restarts the idle window; otherwise count up and hold at the limit.
            if (push || in_ep_data_put) begin
                timer_reg <= '0;
            end else if (!timer_expired) begin
                timer_reg <= timer_reg + TW'(1);
            end
            // A full-size packet must be terminated by a ZLP if no more data follows.
            if (state_reg == ST_COMMIT) begin
                zlp_pend_reg <= pkt_full;
            end
            if (in_ep_acked) begin
                pkt_sent_cnt_reg <= pkt_sent_cnt_reg + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_usb_serial_in_ep.sv
// Directed bench for usb_serial_in_ep: packetisation, timeout/ZLP commits, back-pressure, grant loss and reset.
// A negedge monitor logs puts and commits; each test task compares the logs against hand-derived values.
module tb_usb_serial_in_ep;
    localparam int MAX_PKT = 64;
    localparam int DEPTH   = 16;
    localparam int FT      = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        ep_stall = 1'b0;
    logic        in_ep_req;
    logic        in_ep_grant = 1'b1;
    logic        in_ep_data_free = 1'b1;
    logic        in_ep_data_put;
    logic [7:0]  in_ep_data;
    logic        in_ep_data_done;
    logic        in_ep_stall;
    logic        in_ep_acked = 1'b0;
    logic [15:0] pkt_sent_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] put_log[$];
    int put_cyc[$];
    int done_cyc[$];
    int pkt_sizes[$];
    int cur_pkt = 0;
    int occ = 0;
    int viol = 0;
    int ready_low_occ = -1;

    usb_serial_in_ep #(
        .MAX_PKT(MAX_PKT),
        .FIFO_DEPTH(DEPTH),
        .FLUSH_TIMEOUT(FT)
    ) dut (
        .clk(clk),
        .reset(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .ep_stall(ep_stall),
        .in_ep_req(in_ep_req),
        .in_ep_grant(in_ep_grant),
        .in_ep_data_free(in_ep_data_free),
        .in_ep_data_put(in_ep_data_put),
        .in_ep_data(in_ep_data),
        .in_ep_data_done(in_ep_data_done),
        .in_ep_stall(in_ep_stall),
        .in_ep_acked(in_ep_acked),
        .pkt_sent_cnt(pkt_sent_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Occupancy model: s_ready must track occ < DEPTH; a put needs data, grant and free.
    always @(negedge clk) begin
        if (rst) begin
            occ = 0;
            cur_pkt = 0;
        end else begin
            if (s_ready !== (occ < DEPTH)) viol++;
            if (!s_ready && ready_low_occ < 0) ready_low_occ = occ;
            if (in_ep_data_put) begin
                if (occ == 0 || !in_ep_grant || !in_ep_data_free) viol++;
                put_log.push_back(in_ep_data);
                put_cyc.push_back(cyc);
                cur_pkt++;
            end
            if (in_ep_data_done) begin
                done_cyc.push_back(cyc);
                pkt_sizes.push_back(cur_pkt);
                cur_pkt = 0;
            end
            if (s_valid && s_ready) occ++;
            if (in_ep_data_put) occ--;
        end
    end

    task automatic clear_logs();
        put_log.delete();
        put_cyc.delete();
        done_cyc.delete();
        pkt_sizes.delete();
        viol = 0;
        ready_low_occ = -1;
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            s_data  = first + 8'(i);
            s_valid = 1'b1;
            @(negedge clk);
            while (!s_ready && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 500) begin
                total++;
                bad++;
                $display("FAIL push_timeout: byte %0d not accepted, s_ready=%0b want 1", i, s_ready);
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_dones(input int k, input int limit, input string name);
        int n = 0;
        while (done_cyc.size() < k && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        total++;
        if (done_cyc.size() < k) begin
            bad++;
            $display("FAIL %s: done pulses got %0d want %0d within %0d cycles", name, done_cyc.size(), k, limit);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (in_ep_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", in_ep_req); end
        total++; if (in_ep_data_put !== 1'b0) begin bad++; $display("FAIL reset_put: got %0b want 0", in_ep_data_put); end
        total++; if (in_ep_data_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", in_ep_data_done); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
        total++; if (pkt_sent_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", pkt_sent_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);
        $display("test_reset: checked");
    endtask

    task automatic test_short_packet();
        clear_logs();
        ep_stall = 1'b1;
        #1;
        total++; if (in_ep_stall !== 1'b1) begin bad++; $display("FAIL stall_pass_1: got %0b want 1", in_ep_stall); end
        push_seq(8'h01, 5);
        wait_dones(1, 200, "short_done");
        total++; if (put_log.size() != 5) begin bad++; $display("FAIL short_puts: got %0d want 5", put_log.size()); end
        else for (int i = 0; i < 5; i++) begin
            total++;
            if (put_log[i] !== 8'(i + 1)) begin bad++; $display("FAIL short_data[%0d]: got %02h want %02h", i, put_log[i], 8'(i + 1)); end
        end
        // Last put clears the timer; it reads FT after FT+1 cycles, then COMMIT follows one cycle later.
        total++;
        if (put_cyc.size() != 5 || done_cyc.size() < 1 || done_cyc[0] - put_cyc[4] != FT + 2) begin
            bad++;
            $display("FAIL short_latency: got %0d want %0d", (put_cyc.size() == 5 && done_cyc.size() > 0) ? done_cyc[0] - put_cyc[4] : -1, FT + 2);
        end
        ep_stall = 1'b0;
        #1;
        total++; if (in_ep_stall !== 1'b0) begin bad++; $display("FAIL stall_pass_0: got %0b want 0", in_ep_stall); end
        in_ep_acked = 1'b1;
        @(posedge clk);
        #1;
        in_ep_acked = 1'b0;
        total++; if (pkt_sent_cnt !== 16'd1) begin bad++; $display("FAIL short_acked: got %0d want 1", pkt_sent_cnt); end
        idle_cycles(3 * FT);
        total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL short_no_zlp: got %0d dones want 1", done_cyc.size()); end
        $display("test_short_packet: puts=%0d dones=%0d", put_log.size(), done_cyc.size());
    endtask

    task automatic test_full_packet_zlp();
        bit seen = 1'b0;
        clear_logs();
        push_seq(8'h40, 64);
        wait_dones(1, 400, "full_done");
        total++; if (pkt_sizes.size() < 1 || pkt_sizes[0] != 64) begin bad++; $display("FAIL full_size: got %0d want 64", pkt_sizes.size() > 0 ? pkt_sizes[0] : -1); end
        // pkt_count reaches 64 after the last put; FILL sees it next cycle, COMMIT the one after.
        total++;
        if (put_cyc.size() != 64 || done_cyc.size() < 1 || done_cyc[0] - put_cyc[63] != 2) begin
            bad++;
            $display("FAIL full_latency: got %0d want 2", (put_cyc.size() == 64 && done_cyc.size() > 0) ? done_cyc[0] - put_cyc[63] : -1);
        end
        for (int i = 0; i < FT + 20 && !seen; i++) begin
            @(negedge clk);
            if (in_ep_data_done) seen = 1'b1;
        end
        if (seen) begin
            in_ep_acked = 1'b1;
            @(posedge clk);
            #1;
            in_ep_acked = 1'b0;
        end
        total++; if (!seen) begin bad++; $display("FAIL zlp_seen: got 0 want 1"); end
        total++; if (pkt_sizes.size() != 2 || pkt_sizes[1] != 0) begin bad++; $display("FAIL zlp_size: got %0d packets want 2 with zero puts", pkt_sizes.size()); end
        // Timer expires at put+FT+1; IDLE->REQ->FILL->COMMIT adds three more cycles.
        total++;
        if (put_cyc.size() != 64 || done_cyc.size() != 2 || done_cyc[1] - put_cyc[63] != FT + 4) begin
            bad++;
            $display("FAIL zlp_latency: got %0d want %0d", (put_cyc.size() == 64 && done_cyc.size() == 2) ? done_cyc[1] - put_cyc[63] : -1, FT + 4);
        end
        total++; if (pkt_sent_cnt !== 16'd2) begin bad++; $display("FAIL zlp_ack_same_cycle: got %0d want 2", pkt_sent_cnt); end
        idle_cycles(3 * FT);
        total++; if (done_cyc.size() != 2) begin bad++; $display("FAIL zlp_once: got %0d dones want 2", done_cyc.size()); end
        for (int i = 0; i < 64 && i < put_log.size(); i++) begin
            total++;
            if (put_log[i] !== 8'h40 + 8'(i)) begin bad++; $display("FAIL full_data[%0d]: got %02h want %02h", i, put_log[i], 8'h40 + 8'(i)); end
        end
        $display("test_full_packet_zlp: puts=%0d dones=%0d", put_log.size(), done_cyc.size());
    endtask

    task automatic test_overflow();
        clear_logs();
        in_ep_grant = 1'b0;
        fork
            push_seq(8'h00, 70);
            begin
                int n = 0;
                while (s_ready && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                in_ep_grant = 1'b1;
            end
        join
        wait_dones(2, 600, "ovf_done");
        total++; if (ready_low_occ != DEPTH) begin bad++; $display("FAIL ovf_ready_low: got occ %0d want %0d", ready_low_occ, DEPTH); end
        total++; if (pkt_sizes.size() < 2 || pkt_sizes[0] != 64 || pkt_sizes[1] != 6) begin bad++; $display("FAIL ovf_sizes: got %0d packets want 64 then 6", pkt_sizes.size()); end
        total++; if (put_log.size() != 70) begin bad++; $display("FAIL ovf_puts: got %0d want 70", put_log.size()); end
        else for (int i = 0; i < 70; i++) begin
            total++;
            if (put_log[i] !== 8'(i)) begin bad++; $display("FAIL ovf_data[%0d]: got %02h want %02h", i, put_log[i], 8'(i)); end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL ovf_protocol: got %0d violations want 0", viol); end
        idle_cycles(3 * FT);
        total++; if (done_cyc.size() != 2) begin bad++; $display("FAIL ovf_no_zlp: got %0d dones want 2", done_cyc.size()); end
        $display("test_overflow: puts=%0d dones=%0d", put_log.size(), done_cyc.size());
    endtask

    task automatic test_free_toggle();
        clear_logs();
        fork
            push_seq(8'hB0, 10);
            begin
                for (int i = 0; i < 45; i++) begin
                    @(posedge clk);
                    #1;
                    in_ep_data_free = (((i / 3) % 2) == 1);
                end
                in_ep_data_free = 1'b1;
            end
        join
        wait_dones(1, 300, "free_done");
        total++; if (viol != 0) begin bad++; $display("FAIL free_protocol: got %0d violations want 0", viol); end
        total++; if (pkt_sizes.size() != 1 || pkt_sizes[0] != 10) begin bad++; $display("FAIL free_size: got %0d packets want one of 10", pkt_sizes.size()); end
        total++; if (put_log.size() != 10) begin bad++; $display("FAIL free_puts: got %0d want 10", put_log.size()); end
        else for (int i = 0; i < 10; i++) begin
            total++;
            if (put_log[i] !== 8'hB0 + 8'(i)) begin bad++; $display("FAIL free_data[%0d]: got %02h want %02h", i, put_log[i], 8'hB0 + 8'(i)); end
        end
        $display("test_free_toggle: puts=%0d dones=%0d", put_log.size(), done_cyc.size());
    endtask

    task automatic test_reset_mid_fill();
        clear_logs();
        fork
            push_seq(8'hC0, 12);
            begin
                int n = 0;
                int guard = 0;
                while (n < 10 && guard < 300) begin
                    @(negedge clk);
                    if (in_ep_data_put) n++;
                    guard++;
                end
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
        join
        @(negedge clk);
        total++; if (in_ep_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req: got %0b want 0", in_ep_req); end
        total++; if (in_ep_data_put !== 1'b0) begin bad++; $display("FAIL mid_rst_put: got %0b want 0", in_ep_data_put); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %0b want 1", s_ready); end
        total++; if (pkt_sent_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_cnt: got %0d want 0", pkt_sent_cnt); end
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(2);
        total++; if (put_log.size() != 10) begin bad++; $display("FAIL mid_rst_puts: got %0d want 10", put_log.size()); end
        total++; if (done_cyc.size() != 0) begin bad++; $display("FAIL mid_rst_no_done: got %0d want 0", done_cyc.size()); end
        clear_logs();
        push_seq(8'hD0, 3);
        wait_dones(1, 200, "post_rst_done");
        total++; if (pkt_sizes.size() != 1 || pkt_sizes[0] != 3) begin bad++; $display("FAIL post_rst_size: got %0d packets want one of 3", pkt_sizes.size()); end
        total++; if (put_log.size() != 3) begin bad++; $display("FAIL post_rst_puts: got %0d want 3", put_log.size()); end
        else for (int i = 0; i < 3; i++) begin
            total++;
            if (put_log[i] !== 8'hD0 + 8'(i)) begin bad++; $display("FAIL post_rst_data[%0d]: got %02h want %02h", i, put_log[i], 8'hD0 + 8'(i)); end
        end
        $display("test_reset_mid_fill: puts=%0d dones=%0d", put_log.size(), done_cyc.size());
    endtask

    task automatic test_grant_withheld();
        int req_low = 0;
        clear_logs();
        in_ep_grant = 1'b0;
        push_seq(8'hE0, 8);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ep_req !== 1'b1) req_low++;
        end
        total++; if (req_low != 0) begin bad++; $display("FAIL nogrant_req: got %0d low cycles want 0", req_low); end
        total++; if (put_log.size() != 0) begin bad++; $display("FAIL nogrant_puts: got %0d want 0", put_log.size()); end
        @(posedge clk);
        #1;
        in_ep_grant = 1'b1;
        wait_dones(1, 200, "grant_done");
        total++; if (pkt_sizes.size() != 1 || pkt_sizes[0] != 8) begin bad++; $display("FAIL grant_size: got %0d packets want one of 8", pkt_sizes.size()); end
        total++; if (put_log.size() != 8) begin bad++; $display("FAIL grant_puts: got %0d want 8", put_log.size()); end
        else for (int i = 0; i < 8; i++) begin
            total++;
            if (put_log[i] !== 8'hE0 + 8'(i)) begin bad++; $display("FAIL grant_data[%0d]: got %02h want %02h", i, put_log[i], 8'hE0 + 8'(i)); end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL grant_protocol: got %0d violations want 0", viol); end
        $display("test_grant_withheld: puts=%0d dones=%0d", put_log.size(), done_cyc.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_short_packet();
        test_full_packet_zlp();
        test_overflow();
        test_free_toggle();
        test_reset_mid_fill();
        test_grant_withheld();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
